bp_cfg_link_tx: RTL and testbench



---
 rtl/bp_cfg_link_pkg.sv | 55 +++++
 rtl/bp_common_aviary_pkg.sv | 22 ++
 rtl/bp_cfg_link_tx.sv | 108 ++++++++++
 tb/tb_bp_cfg_link_tx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_cfg_link_pkg.sv
// bp_cfg_link_pkg: shared types for the processor configuration link.
// Register addresses, transmitter FSM states, the packet struct and the
// helpers that build the packet for a given (state, core, mode).
package bp_cfg_link_pkg;

    localparam int bp_cfg_link_dest_width_gp = 8;
    localparam int bp_cfg_link_addr_width_gp = 16;
    localparam int bp_cfg_link_data_width_gp = 32;

    typedef logic [bp_cfg_link_dest_width_gp-1:0] bp_cfg_link_dest_t;
    typedef logic [bp_cfg_link_addr_width_gp-1:0] bp_cfg_link_addr_t;
    typedef logic [bp_cfg_link_data_width_gp-1:0] bp_cfg_link_data_t;

    localparam bp_cfg_link_addr_t bp_cfg_reg_freeze_gp   = 16'h0000;
    localparam bp_cfg_link_addr_t bp_cfg_reg_core_id_gp  = 16'h0001;
    localparam bp_cfg_link_addr_t bp_cfg_reg_cce_mode_gp = 16'h0002;

    typedef enum logic [2:0] {
        e_idle,
        e_freeze,
        e_core_id,
        e_cce_mode,
        e_unfreeze,
        e_done
    } bp_cfg_link_state_e;

    typedef struct packed {
        bp_cfg_link_dest_t dest;
        bp_cfg_link_addr_t addr;
        bp_cfg_link_data_t data;
    } bp_cfg_link_pkt_s;

    function automatic logic bp_cfg_link_sending(input bp_cfg_link_state_e s);
        return s inside {e_freeze, e_core_id, e_cce_mode, e_unfreeze};
    endfunction

    // Freeze writes 1, unfreeze writes 0 to the same register.
    function automatic bp_cfg_link_pkt_s bp_cfg_link_next_pkt(
        input bp_cfg_link_state_e s,
        input bp_cfg_link_dest_t  core,
        input logic               mode
    );
        bp_cfg_link_pkt_s p;
        p.dest = core;
        p.addr = (s == e_core_id)  ? bp_cfg_reg_core_id_gp
               : (s == e_cce_mode) ? bp_cfg_reg_cce_mode_gp
               : bp_cfg_reg_freeze_gp;
        p.data = (s == e_freeze)   ? bp_cfg_link_data_t'(1)
               : (s == e_core_id)  ? bp_cfg_link_data_t'(core)
               : (s == e_cce_mode) ? bp_cfg_link_data_t'(mode)
               : '0;
        return p;
    endfunction

endpackage

// File: rtl/bp_common_aviary_pkg.sv
// bp_common_aviary_pkg: processor configuration catalogue.
// Defines the bp_cfg_e configuration selector and the per-configuration
// parameter table all_cfgs_gp, indexed by bp_cfg_e.
package bp_common_aviary_pkg;

    typedef enum logic [1:0] {
        e_bp_single_core_cfg = 2'd0,
        e_bp_dual_core_cfg   = 2'd1,
        e_bp_quad_core_cfg   = 2'd2
    } bp_cfg_e;

    typedef struct packed {
        int num_core;
    } bp_proc_param_s;

    localparam bp_proc_param_s all_cfgs_gp [3] = '{
        '{num_core: 1},
        '{num_core: 2},
        '{num_core: 4}
    };

endpackage

// File: rtl/bp_cfg_link_tx.sv
// bp_cfg_link_tx: host-side configuration link transmitter.
// On start_i, writes freeze / core id / CCE mode to every core, then
// unfreezes every core, one valid/ready packet per write.
//   clk_i, reset_i     : clock, synchronous active-high reset
//   start_i            : one-cycle request to run the load sequence
//   cce_mode_i         : CCE mode to program (latched on start)
//   cfg_v_o/cfg_ready_i: packet handshake
//   cfg_dest/addr/data : packet payload, held while stalled
//   busy_o, done_o     : sequence in progress / complete (sticky)
module bp_cfg_link_tx
    import bp_common_aviary_pkg::*;
    import bp_cfg_link_pkg::*;
#(
    parameter bp_cfg_e cfg_p            = e_bp_single_core_cfg,
    parameter int      cfg_addr_width_p = 16,
    parameter int      cfg_data_width_p = 32,
    localparam int     num_core_p       = all_cfgs_gp[cfg_p].num_core,
    localparam int     lg_num_core_lp   = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        start_i,
    input  logic                        cce_mode_i,
    output logic                        cfg_v_o,
    output logic [lg_num_core_lp-1:0]   cfg_dest_o,
    output logic [cfg_addr_width_p-1:0] cfg_addr_o,
    output logic [cfg_data_width_p-1:0] cfg_data_o,
    input  logic                        cfg_ready_i,
    output logic                        busy_o,
    output logic                        done_o
);

    bp_cfg_link_state_e        state_q, state_d;
    logic [lg_num_core_lp-1:0] core_cnt_q, core_cnt_d;
    logic                      mode_q, mode_d;
    logic                      done_q, done_d;
    logic                      v_q, v_d;
    bp_cfg_link_pkt_s          pkt_q, pkt_d;
    logic                      fire, last_core;
    logic                      unused_pkt;

    assign fire      = v_q & cfg_ready_i;
    assign last_core = core_cnt_q == lg_num_core_lp'(num_core_p - 1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= e_idle;
            core_cnt_q <= '0;
            mode_q     <= 1'b0;
            done_q     <= 1'b0;
            v_q        <= 1'b0;
            pkt_q      <= '0;
        end else begin
            state_q    <= state_d;
            core_cnt_q <= core_cnt_d;
            mode_q     <= mode_d;
            done_q     <= done_d;
            v_q        <= v_d;
            pkt_q      <= pkt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        core_cnt_d = core_cnt_q;
        mode_d     = mode_q;
        done_d     = done_q;
        case (state_q)
            e_idle: if (start_i) begin
                state_d    = e_freeze;
                core_cnt_d = '0;
                mode_d     = cce_mode_i;
                done_d     = 1'b0;
            end
            e_freeze:  state_d = fire ? e_core_id : state_q;
            e_core_id: state_d = fire ? e_cce_mode : state_q;
            e_cce_mode: if (fire) begin
                state_d    = last_core ? e_unfreeze : e_freeze;
                core_cnt_d = last_core ? '0 : core_cnt_q + 1'b1;
            end
            e_unfreeze: if (fire) begin
                state_d    = last_core ? e_done : e_unfreeze;
                core_cnt_d = last_core ? '0 : core_cnt_q + 1'b1;
            end
            e_done: begin
                state_d = e_idle;
                done_d  = 1'b1;
            end
            default: state_d = e_idle;
        endcase
    end

    // Payload is registered from the next state, so it stays put while
    // the receiver stalls (state and counter do not move without a fire).
    always_comb begin
        v_d   = bp_cfg_link_sending(state_d);
        pkt_d = v_d ? bp_cfg_link_next_pkt(state_d, bp_cfg_link_dest_t'(core_cnt_d), mode_d) : '0;
    end

    assign cfg_v_o    = v_q;
    assign cfg_dest_o = pkt_q.dest[lg_num_core_lp-1:0];
    assign cfg_addr_o = pkt_q.addr[cfg_addr_width_p-1:0];
    assign cfg_data_o = pkt_q.data[cfg_data_width_p-1:0];
    assign busy_o     = (state_q != e_idle) && (state_q != e_done);
    assign done_o     = done_q;
    assign unused_pkt = ^pkt_q;

endmodule

// File: tb/tb_bp_cfg_link_tx.sv
// tb_bp_cfg_link_tx: randomized self-checking bench for single, dual and quad core links.
module tb_bp_cfg_link_tx;
    import bp_common_aviary_pkg::*;

    typedef struct {
        logic [1:0]  dest;
        logic [15:0] addr;
        logic [31:0] data;
    } exp_t;

    localparam int ncore [3] = '{1, 2, 4};

    logic        clk = 1'b0;
    logic        rst   [3];
    logic        start [3];
    logic        mode  [3];
    logic        ready [3];
    logic        v     [3];
    logic        busy  [3];
    logic        done  [3];
    logic [1:0]  dest  [3];
    logic [15:0] addr  [3];
    logic [31:0] data  [3];
    logic [0:0]  d0, d1;
    logic [1:0]  d2;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign dest[0] = {1'b0, d0};
    assign dest[1] = {1'b0, d1};
    assign dest[2] = d2;

    bp_cfg_link_tx #(.cfg_p(e_bp_single_core_cfg)) u_single (
        .clk_i(clk), .reset_i(rst[0]), .start_i(start[0]), .cce_mode_i(mode[0]),
        .cfg_v_o(v[0]), .cfg_dest_o(d0), .cfg_addr_o(addr[0]), .cfg_data_o(data[0]),
        .cfg_ready_i(ready[0]), .busy_o(busy[0]), .done_o(done[0])
    );
    bp_cfg_link_tx #(.cfg_p(e_bp_dual_core_cfg)) u_dual (
        .clk_i(clk), .reset_i(rst[1]), .start_i(start[1]), .cce_mode_i(mode[1]),
        .cfg_v_o(v[1]), .cfg_dest_o(d1), .cfg_addr_o(addr[1]), .cfg_data_o(data[1]),
        .cfg_ready_i(ready[1]), .busy_o(busy[1]), .done_o(done[1])
    );
    bp_cfg_link_tx #(.cfg_p(e_bp_quad_core_cfg)) u_quad (
        .clk_i(clk), .reset_i(rst[2]), .start_i(start[2]), .cce_mode_i(mode[2]),
        .cfg_v_o(v[2]), .cfg_dest_o(d2), .cfg_addr_o(addr[2]), .cfg_data_o(data[2]),
        .cfg_ready_i(ready[2]), .busy_o(busy[2]), .done_o(done[2])
    );

    // Full sequence with optional random backpressure, a 3-cycle stall before
    // packet stall_at, and an optional ignored restart while busy.
    task automatic run_seq(input int k, input bit m, input int pct, input bit poke, input int stall_at);
        exp_t        q[$];
        exp_t        e;
        int          n = ncore[k];
        int          got = 0;
        int          stall_left = 3;
        int          guard = 0;
        int          t0, t1;
        logic        prev_hold = 1'b0;
        logic [49:0] prev = '0;
        for (int c = 0; c < n; c++) begin
            q.push_back('{dest: 2'(c), addr: 16'h0, data: 32'd1});
            q.push_back('{dest: 2'(c), addr: 16'h1, data: 32'(c)});
            q.push_back('{dest: 2'(c), addr: 16'h2, data: 32'(m)});
        end
        for (int c = 0; c < n; c++) q.push_back('{dest: 2'(c), addr: 16'h0, data: 32'd0});
        @(negedge clk);
        start[k] = 1'b1;
        mode[k]  = m;
        ready[k] = 1'b0;
        t0 = cyc + 1;
        @(negedge clk);
        start[k] = 1'b0;
        checks++;
        if (v[k] !== 1'b1 || busy[k] !== 1'b1 || done[k] !== 1'b0) begin
            errors++;
            $display("FAIL start_resp k=%0d v/busy/done got %b%b%b exp 110", k, v[k], busy[k], done[k]);
        end
        while (q.size() > 0 && guard < 400) begin
            guard++;
            if (poke && guard == 3) begin
                start[k] = 1'b1;
                mode[k]  = ~m;
                checks++;
                if (busy[k] !== 1'b1) begin
                    errors++;
                    $display("FAIL poke_busy k=%0d got %b exp 1", k, busy[k]);
                end
            end else start[k] = 1'b0;
            checks++;
            if (v[k] !== 1'b1) begin
                errors++;
                $display("FAIL v_drop k=%0d pkt=%0d got %b exp 1", k, got, v[k]);
            end
            if (prev_hold) begin
                checks++;
                if ({dest[k], addr[k], data[k]} !== prev) begin
                    errors++;
                    $display("FAIL hold k=%0d got %h exp %h", k, {dest[k], addr[k], data[k]}, prev);
                end
            end
            if (got == stall_at && stall_left > 0) begin
                ready[k] = 1'b0;
                stall_left--;
            end else ready[k] = ($urandom_range(99) < pct);
            if (v[k] && ready[k]) begin
                e = q.pop_front();
                checks++;
                if (dest[k] !== e.dest || addr[k] !== e.addr || data[k] !== e.data) begin
                    errors++;
                    $display("FAIL pkt k=%0d idx=%0d got %0h/%0h/%0h exp %0h/%0h/%0h",
                             k, got, dest[k], addr[k], data[k], e.dest, e.addr, e.data);
                end
                got++;
                prev_hold = 1'b0;
            end else begin
                prev_hold = v[k];
                prev = {dest[k], addr[k], data[k]};
            end
            @(negedge clk);
        end
        start[k] = 1'b0;
        ready[k] = 1'b0;
        checks++;
        if (guard >= 400) begin
            errors++;
            $display("FAIL timeout k=%0d got %0d packets exp %0d", k, got, 4 * n);
        end
        checks++;
        if (v[k] !== 1'b0 || busy[k] !== 1'b0 || done[k] !== 1'b0) begin
            errors++;
            $display("FAIL end_state k=%0d v/busy/done got %b%b%b exp 000", k, v[k], busy[k], done[k]);
        end
        @(negedge clk);
        t1 = cyc;
        checks++;
        if (v[k] !== 1'b0 || busy[k] !== 1'b0 || done[k] !== 1'b1) begin
            errors++;
            $display("FAIL done k=%0d v/busy/done got %b%b%b exp 001", k, v[k], busy[k], done[k]);
        end
        if (pct == 100 && stall_at < 0) begin
            checks++;
            if (t1 - t0 != 4 * n + 1) begin
                errors++;
                $display("FAIL latency k=%0d got %0d exp %0d", k, t1 - t0, 4 * n + 1);
            end
        end
        ready[k] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (v[k] !== 1'b0 || done[k] !== 1'b1) begin
                errors++;
                $display("FAIL extra_pkt k=%0d v/done got %b%b exp 01", k, v[k], done[k]);
            end
        end
        ready[k] = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (v[k] !== 1'b0 || busy[k] !== 1'b0 || done[k] !== 1'b0 ||
                dest[k] !== 2'd0 || addr[k] !== 16'd0 || data[k] !== 32'd0) begin
                errors++;
                $display("FAIL reset k=%0d v/busy/done %b%b%b payload %0h/%0h/%0h exp all 0",
                         k, v[k], busy[k], done[k], dest[k], addr[k], data[k]);
            end
            rst[k] = 1'b0;
            ready[k] = 1'b1;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (v[k] !== 1'b0 || busy[k] !== 1'b0) begin
                errors++;
                $display("FAIL idle_ready k=%0d v/busy got %b%b exp 00", k, v[k], busy[k]);
            end
            ready[k] = 1'b0;
        end
    endtask

    task automatic test_single();
        run_seq(0, 1'b1, 100, 1'b0, -1);
    endtask

    task automatic test_quad();
        run_seq(2, 1'b0, 100, 1'b0, -1);
    endtask

    task automatic test_backpressure();
        run_seq(2, 1'b0, 100, 1'b0, 1);
    endtask

    task automatic test_busy_restart();
        run_seq(1, 1'b1, 70, 1'b1, -1);
        run_seq(2, 1'b0, 60, 1'b1, -1);
    endtask

    task automatic test_reset_mid();
        run_seq(1, 1'b1, 100, 1'b0, -1);
        @(negedge clk);
        start[1] = 1'b1;
        mode[1]  = 1'b0;
        @(negedge clk);
        start[1] = 1'b0;
        ready[1] = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (v[1] !== 1'b1 || addr[1] !== 16'h2) begin
            errors++;
            $display("FAIL third_pkt v/addr got %b/%0h exp 1/2", v[1], addr[1]);
        end
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1]   = 1'b0;
        ready[1] = 1'b0;
        checks++;
        if (v[1] !== 1'b0 || busy[1] !== 1'b0 || done[1] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset v/busy/done got %b%b%b exp 000", v[1], busy[1], done[1]);
        end
        run_seq(1, 1'b1, 80, 1'b0, -1);
        @(negedge clk);
        start[1] = 1'b1;
        rst[1]   = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        rst[1]   = 1'b0;
        @(negedge clk);
        checks++;
        if (v[1] !== 1'b0 || busy[1] !== 1'b0 || done[1] !== 1'b0) begin
            errors++;
            $display("FAIL start_with_reset v/busy/done got %b%b%b exp 000", v[1], busy[1], done[1]);
        end
    endtask

    task automatic test_rerun();
        run_seq(0, 1'b0, 100, 1'b0, -1);
        run_seq(2, 1'b1, 100, 1'b0, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            int k;
            k = $urandom_range(2);
            run_seq(k, 1'($urandom_range(1)), 30 + $urandom_range(70), k > 0 ? 1'($urandom_range(1)) : 1'b0, -1);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k]   = 1'b1;
            start[k] = 1'b0;
            mode[k]  = 1'b0;
            ready[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        test_single();
        test_quad();
        test_backpressure();
        test_busy_restart();
        test_reset_mid();
        test_rerun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
